// File: rtl/nibbler_pkg.sv
// Shared types, widths and nibble helpers for the program byte path.
package nibbler_pkg;

   localparam int PROG_ADDR_W = 12;
   localparam int PROG_BYTE_W = 8;
   localparam int NIBBLE_W    = 4;

   localparam logic [NIBBLE_W-1:0] HALT_OPC_DEF = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      VALID
   } fetch_src_state_t;

   function automatic logic [NIBBLE_W-1:0] instr_of(
      input logic [PROG_BYTE_W-1:0] b
   );
      return b[PROG_BYTE_W-1:NIBBLE_W];
   endfunction

   function automatic logic [NIBBLE_W-1:0] opnd_of(
      input logic [PROG_BYTE_W-1:0] b
   );
      return b[NIBBLE_W-1:0];
   endfunction

endpackage

// File: rtl/program_byte_source_if.sv
// Valid/ready byte handshake between the byte source and Fetch.
interface program_byte_source_if;
   import nibbler_pkg::*;

   logic [PROG_BYTE_W-1:0] program_byte;
   logic                   byte_valid;
   logic                   byte_ready;

   modport master (
      output program_byte,
      output byte_valid,
      input  byte_ready
   );

   modport slave (
      input  program_byte,
      input  byte_valid,
      output byte_ready
   );

endinterface

// File: rtl/program_byte_source_pc_counter.sv
// Program counter: jump load has priority over increment; wraps naturally.
module pc_counter #(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/program_byte_source.sv
// Program byte source: PC, ROM read sequencing, byte handshake to Fetch.
// Optional halt detection enabled by PROGRAM_BYTE_SOURCE_HALT_EN.
module program_byte_source
   import nibbler_pkg::*;
#(
   parameter int                  ADDR_W   = PROG_ADDR_W,
   parameter int                  ROM_LAT  = 1,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0,
   parameter logic [NIBBLE_W-1:0] HALT_OPC = HALT_OPC_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   jump_en,
   input  logic [ADDR_W-1:0]      jump_addr,
   output logic [ADDR_W-1:0]      rom_addr,
   output logic                   rom_rd,
   input  logic [PROG_BYTE_W-1:0] rom_data,
   program_byte_source_if.master  fetch,
   output logic [ADDR_W-1:0]      pc,
   output logic                   halted
);

`ifdef PROGRAM_BYTE_SOURCE_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   localparam logic [2:0] LAT_M1 = 3'(ROM_LAT - 1);

   fetch_src_state_t state;
   logic [2:0]       cnt;
   logic             hs;
   logic             halt_hit;

   assign hs       = fetch.byte_valid && fetch.byte_ready;
   assign halt_hit = HALT_EN && hs &&
                     (instr_of(fetch.program_byte) == HALT_OPC);
   assign rom_addr = pc;

   pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (jump_en),
      .load_val (jump_addr),
      .inc      (hs && !jump_en),
      .pc       (pc)
   );

   // A jump overrides every state, so any read still in the ROM is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         rom_rd             <= 1'b0;
         cnt                <= '0;
         fetch.program_byte <= '0;
         fetch.byte_valid   <= 1'b0;
         halted             <= 1'b0;
      end else begin
         rom_rd <= 1'b0;
         if (jump_en) begin
            halted           <= 1'b0;
            fetch.byte_valid <= 1'b0;
            if (en) begin
               state  <= ISSUE;
               rom_rd <= 1'b1;
            end else begin
               state <= IDLE;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (en && !halted) begin
                     state  <= ISSUE;
                     rom_rd <= 1'b1;
                  end
               end
               ISSUE: begin
                  cnt   <= LAT_M1;
                  state <= WAIT;
               end
               WAIT: begin
                  if (cnt == '0) begin
                     fetch.program_byte <= rom_data;
                     fetch.byte_valid   <= 1'b1;
                     state              <= VALID;
                  end else begin
                     cnt <= cnt - 3'd1;
                  end
               end
               VALID: begin
                  if (fetch.byte_ready) begin
                     fetch.byte_valid <= 1'b0;
                     if (halt_hit) begin
                        halted <= 1'b1;
                        state  <= IDLE;
                     end else if (en) begin
                        state  <= ISSUE;
                        rom_rd <= 1'b1;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/program_byte_source.md
Name: program_byte_source

Overview:
Supplies 8-bit program bytes to the Fetch stage, which splits each byte into instruction and operand nibbles. Owns the program counter, issues reads to the synchronous program ROM and waits out its fixed latency. Presents each byte to Fetch with a valid/ready handshake. Supports jumps that redirect the PC and discard any in-flight byte.

Parameters:
ADDR_W, 12, program counter / ROM address width (4K-byte program space)
ROM_LAT, 1, cycles from rom_rd to rom_data valid; legal range 1..7
RESET_PC, 0, PC value after reset
HALT_OPC, 4'hF, instruction nibble treated as halt (used only with optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; fetching starts or continues while high
jump_en  in  1  one-cycle pulse requesting a PC redirect
jump_addr  in  ADDR_W  jump target
rom_addr  out  ADDR_W  ROM read address
rom_rd  out  1  ROM read strobe, one cycle per read
rom_data  in  8  ROM read data, valid ROM_LAT cycles after rom_rd
program_byte  out  8  byte to Fetch; upper nibble is instruction, lower nibble is operand
byte_valid  out  1  program_byte is valid
byte_ready  in  1  Fetch accepts the byte
pc  out  ADDR_W  address of the byte currently presented or in flight
halted  out  1  halt opcode reached (optional feature; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous and active-low.
- Reset values: state IDLE, pc=RESET_PC, rom_addr=RESET_PC, rom_rd=0, program_byte=8'h00, byte_valid=0, halted=0, latency counter=0. Reset takes effect immediately at any point, including mid-read; the returning rom_data is ignored.
- FSM states: IDLE, ISSUE, WAIT, VALID.
- IDLE: outputs quiet. If en=1, go to ISSUE.
- ISSUE: rom_rd=1 and rom_addr=pc for exactly one cycle. Load the counter with ROM_LAT-1. Go to WAIT.
- WAIT: counter decrements each cycle. On the cycle the counter reads 0, rom_data is valid and is registered into program_byte. Next state is VALID, with byte_valid=1 from the following cycle.
- ROM_LAT=1: WAIT lasts one cycle. The first byte_valid appears 3 cycles after en is sampled high in IDLE.
- VALID: program_byte and byte_valid hold stable until byte_valid&&byte_ready.
- On handshake: pc <= pc+1, wrapping modulo 2^ADDR_W (for ADDR_W=12, 12'hFFF -> 12'h000). Next state is ISSUE if en=1, else IDLE. byte_valid drops for at least one cycle between bytes; no back-to-back streaming.
- en deasserted: it is sampled only in IDLE and at handshake. Bytes already in flight still complete and are presented.
- jump_en, in any state:
  - pc <= jump_addr.
  - byte_valid <= 0.
  - Any pending rom_data is discarded.
  - Next state is ISSUE if en=1, else IDLE.
- jump_en has priority over a simultaneous handshake: the presented byte counts as consumed, pc takes jump_addr, not pc+1.
- jump_en in the same cycle as rom_rd: that read's data is discarded.
- Arithmetic: pc increment is unsigned with wrap-around. No other arithmetic.

Optional Feature:
Macro PROGRAM_BYTE_SOURCE_HALT_EN.
- Defined: when a handshake accepts a byte whose upper nibble equals HALT_OPC, the FSM goes to IDLE and halted=1, sticky. pc still increments. en is ignored while halted. Only jump_en or rst_n clears halted. jump_en clears halted and resumes per en.
- Undefined: no halt detection. halted is constant 0. HALT_OPC is unused.

Decomposition:
- Shared package nibbler_pkg:
  - state enum fetch_src_state_t (IDLE, ISSUE, WAIT, VALID)
  - constants PROG_ADDR_W=12, PROG_BYTE_W=8, NIBBLE_W=4
  - default HALT_OPC
  - functions instr_of(byte) and opnd_of(byte)
- One natural sub-module: pc_counter (ADDR_W register with load, increment, wrap and reset value). The FSM, latency counter and output registers stay in the top module.

Test Plan:
- Reset and basic read: rst_n low then high, en=1, ROM[0]=8'h3C, ROM_LAT=1 -> rom_rd with rom_addr=0 one cycle after en; byte_valid=1 with program_byte=8'h3C two cycles later; instruction nibble 3, operand nibble C.
- Backpressure: byte_ready=0 for 5 cycles while byte_valid=1 -> program_byte held, pc unchanged, no extra rom_rd; byte_ready=1 -> pc=1 and the next rom_rd is to addr 1.
- Wrap-around: jump to 12'hFFF with ROM[FFF]=8'hF0, ROM[000]=8'h0F -> bytes F0 then 0F presented; pc goes FFF -> 000.
- Jump during WAIT with ROM_LAT=3: jump_en to 12'h040 mid-wait -> stale data never presented; next byte is ROM[040].
- Jump coinciding with handshake, and async reset mid-WAIT: pc=jump_addr, not pc+1. A second run asserts rst_n=0 mid-WAIT -> all outputs reset immediately and no byte_valid follows.
- Halt (with PROGRAM_BYTE_SOURCE_HALT_EN): ROM[2]=8'hF0 -> after its handshake halted=1, no further rom_rd with en=1; jump_en to 0 clears halted and fetching resumes.
